sponge_ctrl: RTL



---
 rtl/sponge_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sponge_ctrl.sv
// Sequencer between the SHA-3 padder and a multi-cycle Keccak-f permutation core:
// feeds blocks, waits on each permutation, holds the digest under valid/ack, then clears the core.
module sponge_ctrl #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [575:0]      blk_in,
    input  logic              blk_valid,
    input  logic              blk_last,
    output logic              blk_ack,
    output logic              perm_reset,
    output logic [575:0]      perm_in,
    output logic              perm_in_ready,
    input  logic              perm_ack,
    input  logic [1599:0]     perm_out,
    input  logic              perm_out_ready,
    output logic [511:0]      digest,
    output logic              digest_valid,
    input  logic              digest_ack,
    output logic [CNT_W-1:0]  blk_count,
    output logic              busy,
    output logic              err
);

    localparam int               TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_FEED  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [TIMER_W-1:0] timer_r, timer_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               last_r, last_nxt_s;
    logic               err_r, err_nxt_s;
    logic [511:0]       digest_r, digest_nxt_s;
    logic               dv_r, busy_r, clear_r;
    logic               feed_s;
    logic               perm_out_unused_s;

    // Only the top 512 bits of the state form the digest; the capacity part is dropped.
    assign perm_out_unused_s = ^perm_out[1087:0];

    assign feed_s        = (state_r == ST_FEED);
    assign perm_in       = blk_in;
    assign perm_in_ready = blk_valid & feed_s;
    assign blk_ack       = perm_ack & feed_s;
    assign perm_reset    = reset | clear_r;
    assign digest        = digest_r;
    assign digest_valid  = dv_r;
    assign blk_count     = cnt_r;
    assign busy          = busy_r;
    assign err           = err_r;

    // Next-state and datapath update logic of the sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        timer_nxt_s  = timer_r;
        cnt_nxt_s    = cnt_r;
        last_nxt_s   = last_r;
        err_nxt_s    = err_r;
        digest_nxt_s = digest_r;
        case (state_r)
            ST_FEED: begin
                if (perm_ack) begin
                    last_nxt_s  = blk_last;
                    timer_nxt_s = '0;
                    state_nxt_s = ST_WAIT;
                    if (cnt_r != CNT_MAX) begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end else begin
                    state_nxt_s = ST_FEED;
                end
            end
            ST_WAIT: begin
                timer_nxt_s = timer_r + TIMER_ONE;
                // A finishing permutation wins over a watchdog expiry in the same cycle.
                if (perm_out_ready) begin
                    if (last_r) begin
                        digest_nxt_s = perm_out[1599:1088];
                        state_nxt_s  = ST_DONE;
                    end else begin
                        state_nxt_s  = ST_FEED;
                    end
                end else if (timer_r == TIMER_LAST) begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (digest_ack) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_CLEAR: begin
                cnt_nxt_s   = '0;
                last_nxt_s  = 1'b0;
                state_nxt_s = ST_FEED;
            end
            default: begin
                state_nxt_s = ST_FEED;
            end
        endcase
    end

    // State, counters, digest and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_FEED;
            timer_r  <= '0;
            cnt_r    <= '0;
            last_r   <= 1'b0;
            err_r    <= 1'b0;
            digest_r <= '0;
            dv_r     <= 1'b0;
            busy_r   <= 1'b0;
            clear_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            timer_r  <= timer_nxt_s;
            cnt_r    <= cnt_nxt_s;
            last_r   <= last_nxt_s;
            err_r    <= err_nxt_s;
            digest_r <= digest_nxt_s;
            dv_r     <= (state_nxt_s == ST_DONE);
            busy_r   <= (state_nxt_s != ST_FEED);
            clear_r  <= (state_nxt_s == ST_CLEAR);
        end
    end

endmodule
